// File: rtl/sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram_fifo_ctrl
// Single-clock FIFO controller that masters an external
// fakeram_1rw1r_12w128d_sram macro. Pushes are written through the macro's
// rw0 port. Reads are issued through its r0 port into a 2-entry prefetch
// buffer. The buffer hides the macro's 1-cycle read latency, so the pop side
// has registered valid/data and can deliver one word per cycle.
//
// Ports:
//   clk           clock (also drives both macro clocks externally)
//   rst_n         synchronous, active-low reset
//   push_valid    write request
//   push_ready    FIFO can accept a word
//   push_data     write word
//   pop_valid     head word available (registered)
//   pop_ready     consumer accepts the head word
//   pop_data      head word (registered)
//   level         words held: RAM + in-flight read + prefetch buffer
//   rw0_ce_out    macro rw0 chip enable
//   rw0_we_out    macro rw0 write enable
//   rw0_addr_out  macro rw0 address (0 when idle)
//   rw0_wd_out    macro rw0 write data (0 when idle)
//   rw0_rd_in     macro rw0 read data (not used)
//   r0_ce_out     macro r0 chip enable
//   r0_addr_out   macro r0 address
//   r0_rd_in      macro r0 read data, valid the cycle after r0_ce_out
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_fifo_ctrl #(
  parameter int BITS       = 12,
  parameter int WORD_DEPTH = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [BITS-1:0]       push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [BITS-1:0]       pop_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  rw0_ce_out,
  output logic                  rw0_we_out,
  output logic [ADDR_WIDTH-1:0] rw0_addr_out,
  output logic [BITS-1:0]       rw0_wd_out,
  input  logic [BITS-1:0]       rw0_rd_in,
  output logic                  r0_ce_out,
  output logic [ADDR_WIDTH-1:0] r0_addr_out,
  input  logic [BITS-1:0]       r0_rd_in
);

  localparam int PW = ADDR_WIDTH + 1;

  // The macro depth must be a full power of two so the wrap-bit pointers work.
  if (WORD_DEPTH != (2 ** ADDR_WIDTH)) begin : g_depth_check
    $error("sram_fifo_ctrl: WORD_DEPTH must equal 2**ADDR_WIDTH");
  end

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PW-1:0]   wptr, wptr_nx;
  logic [PW-1:0]   rptr, rptr_nx;
  logic            inflight, inflight_nx;
  logic [1:0]      buf_cnt, buf_cnt_nx;
  logic [BITS-1:0] head, head_nx;
  logic [BITS-1:0] tail, tail_nx;
  logic [PW-1:0]   level_nx;

  logic            ram_empty;
  logic            ram_full;
  logic            push_fire;
  logic            pop_fire;
  logic            rd_issue;
  logic [2:0]      occ;

  // rw0 read data is never used; fold it into a deliberately unused net.
  logic            unused_rd;
  assign unused_rd = ^rw0_rd_in;

  // Pointer compare, handshakes, macro port drive and read-issue decision.
  always_comb begin
    ram_empty  = (wptr == rptr);
    ram_full   = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                 (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    push_ready = rst_n && !ram_full;
    push_fire  = push_valid && push_ready;
    pop_fire   = pop_valid && pop_ready;

    // Words that will be in the buffer once the outstanding read lands and
    // the current pop retires; a new read may only be issued if it will fit.
    occ        = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop_fire};
    rd_issue   = rst_n && !ram_empty && (occ < 3'd2);

    // Idle rw0 address/data are forced to 0 so nothing undefined reaches the
    // macro pins.
    rw0_ce_out   = push_fire;
    rw0_we_out   = push_fire;
    if (push_fire) begin
      rw0_addr_out = wptr[ADDR_WIDTH-1:0];
      rw0_wd_out   = push_data;
    end else begin
      rw0_addr_out = {ADDR_WIDTH{1'b0}};
      rw0_wd_out   = {BITS{1'b0}};
    end

    r0_ce_out   = rd_issue;
    r0_addr_out = rptr[ADDR_WIDTH-1:0];
  end

  // Next-state for pointers and the prefetch buffer.
  always_comb begin
    if (push_fire) begin
      wptr_nx = wptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      wptr_nx = wptr;
    end

    if (rd_issue) begin
      rptr_nx = rptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      rptr_nx = rptr;
    end

    inflight_nx = rd_issue;

    head_nx    = head;
    tail_nx    = tail;
    buf_cnt_nx = buf_cnt;

    // r0_rd_in is only looked at when a read was issued last cycle; at any
    // other time the macro output is undefined.
    case ({inflight, pop_fire})
      2'b10: begin
        buf_cnt_nx = buf_cnt + 2'd1;
        if (buf_cnt == 2'd0) begin
          head_nx = r0_rd_in;
        end else begin
          tail_nx = r0_rd_in;
        end
      end
      2'b01: begin
        buf_cnt_nx = buf_cnt - 2'd1;
        head_nx    = tail;
      end
      2'b11: begin
        // Capture and pop together: the head advances, the count holds.
        if (buf_cnt == 2'd1) begin
          head_nx = r0_rd_in;
        end else begin
          head_nx = tail;
          tail_nx = r0_rd_in;
        end
      end
      default: begin
        buf_cnt_nx = buf_cnt;
      end
    endcase

    level_nx = (wptr_nx - rptr_nx) +
               {{(PW-1){1'b0}}, inflight_nx} +
               {{(PW-2){1'b0}}, buf_cnt_nx};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= {PW{1'b0}};
      rptr      <= {PW{1'b0}};
      inflight  <= 1'b0;
      buf_cnt   <= 2'd0;
      head      <= {BITS{1'b0}};
      tail      <= {BITS{1'b0}};
      pop_valid <= 1'b0;
      level     <= {PW{1'b0}};
    end else begin
      wptr      <= wptr_nx;
      rptr      <= rptr_nx;
      inflight  <= inflight_nx;
      buf_cnt   <= buf_cnt_nx;
      head      <= head_nx;
      tail      <= tail_nx;
      pop_valid <= (buf_cnt_nx != 2'd0);
      level     <= level_nx;
    end
  end

  assign pop_data = head;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_ctrl
// Directed bench for sram_fifo_ctrl with a behavioural model of the
// 1rw1r macro and a scoreboard queue of accepted words.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_fifo_ctrl;

  localparam int BITS = 12;
  localparam int AW   = 7;
  // Value the macro model drives on r0 when no read was issued; it is never
  // pushed, so seeing it at pop_data means an unissued cycle was captured.
  localparam logic [BITS-1:0] POISON = 12'hFA5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            push_valid;
  logic            push_ready;
  logic [BITS-1:0] push_data;
  logic            pop_valid;
  logic            pop_ready;
  logic [BITS-1:0] pop_data;
  logic [AW:0]     level;
  logic            rw0_ce_out;
  logic            rw0_we_out;
  logic [AW-1:0]   rw0_addr_out;
  logic [BITS-1:0] rw0_wd_out;
  logic [BITS-1:0] rw0_rd_in;
  logic            r0_ce_out;
  logic [AW-1:0]   r0_addr_out;
  logic [BITS-1:0] r0_rd_in;

  sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(128), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .level(level),
    .rw0_ce_out(rw0_ce_out), .rw0_we_out(rw0_we_out),
    .rw0_addr_out(rw0_addr_out), .rw0_wd_out(rw0_wd_out), .rw0_rd_in(rw0_rd_in),
    .r0_ce_out(r0_ce_out), .r0_addr_out(r0_addr_out), .r0_rd_in(r0_rd_in)
  );

  always #5 clk = ~clk;

  // Macro model: rw0 write, r0 read with one cycle of latency.
  logic [BITS-1:0] mem [0:127];
  assign rw0_rd_in = 12'h000;
  always @(posedge clk) begin
    if (rw0_ce_out && rw0_we_out) mem[rw0_addr_out] <= rw0_wd_out;
    if (r0_ce_out) r0_rd_in <= mem[r0_addr_out];
    else           r0_rd_in <= POISON;
  end

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [BITS-1:0] sb[$];
  logic [AW-1:0]   exp_waddr = 7'd0;
  logic [AW-1:0]   exp_raddr = 7'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, update the
  // scoreboard for the handshakes that fire at the coming edge.
  task automatic step(input logic pv, input logic [BITS-1:0] pd, input logic pr);
    logic pf, popf;
    chk("level", {24'd0, level}, sb.size());
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    #1;
    pf   = pv && push_ready;
    popf = rst_n && pop_valid && pr;
    chk("rw0_ce", {31'd0, rw0_ce_out}, {31'd0, pf});
    chk("rw0_we", {31'd0, rw0_we_out}, {31'd0, pf});
    if (pf) begin
      chk("rw0_addr", {25'd0, rw0_addr_out}, {25'd0, exp_waddr});
      chk("rw0_wd", {20'd0, rw0_wd_out}, {20'd0, pd});
      sb.push_back(pd);
      exp_waddr = exp_waddr + 7'd1;
    end else begin
      chk("rw0_addr_idle", {25'd0, rw0_addr_out}, 32'd0);
      chk("rw0_wd_idle", {20'd0, rw0_wd_out}, 32'd0);
    end
    if (!rst_n) begin
      chk("r0_ce_rst", {31'd0, r0_ce_out}, 32'd0);
    end
    if (r0_ce_out) begin
      chk("r0_addr", {25'd0, r0_addr_out}, {25'd0, exp_raddr});
      exp_raddr = exp_raddr + 7'd1;
    end
    if (popf) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", {31'd0, pop_valid}, 32'd0);
      end else begin
        chk("pop_data", {20'd0, pop_data}, {20'd0, sb.pop_front()});
      end
      pops++;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      exp_waddr = 7'd0;
      exp_raddr = 7'd0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) step(1'b0, 12'h000, 1'b1);
    chk("drain_done", sb.size(), 32'd0);
    step(1'b0, 12'h000, 1'b1);
    chk("drain_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("drain_level", {24'd0, level}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 3 cycles with a pending push.
    rst_n = 1'b0; push_valid = 1'b1; push_data = 12'h555; pop_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_push_ready", {31'd0, push_ready}, 32'd0);
    chk("rst_rw0_ce", {31'd0, rw0_ce_out}, 32'd0);
    chk("rst_r0_ce", {31'd0, r0_ce_out}, 32'd0);
    chk("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("rst_level", {24'd0, level}, 32'd0);
    chk("rst_pop_data", {20'd0, pop_data}, 32'd0);
    rst_n = 1'b1;

    // Single word: push at edge k, read issued before k+1, valid after k+2.
    step(1'b1, 12'hABC, 1'b1);
    chk("sw_level_k", {24'd0, level}, 32'd1);
    chk("sw_r0_ce", {31'd0, r0_ce_out}, 32'd1);
    chk("sw_r0_addr", {25'd0, r0_addr_out}, 32'd0);
    step(1'b0, 12'h000, 1'b1);
    chk("sw_level_k1", {24'd0, level}, 32'd1);
    chk("sw_valid_k1", {31'd0, pop_valid}, 32'd0);
    step(1'b0, 12'h000, 1'b1);
    chk("sw_level_k2", {24'd0, level}, 32'd1);
    chk("sw_valid_k2", {31'd0, pop_valid}, 32'd1);
    chk("sw_data_k2", {20'd0, pop_data}, 32'hABC);
    step(1'b0, 12'h000, 1'b1);
    chk("sw_level_k3", {24'd0, level}, 32'd0);
    chk("sw_valid_k3", {31'd0, pop_valid}, 32'd0);

    // Fill to capacity: 128 in RAM plus 2 in the prefetch buffer.
    for (int i = 0; i < 130; i++) begin
      chk("fill_ready", {31'd0, push_ready}, 32'd1);
      step(1'b1, 12'(i + 16), 1'b0);
    end
    chk("full_push_ready", {31'd0, push_ready}, 32'd0);
    chk("full_level", {24'd0, level}, 32'd130);
    repeat (3) step(1'b1, 12'h7EE, 1'b0);
    chk("full_level_hold", {24'd0, level}, 32'd130);
    drain();

    // Streaming: first pop at the 4th cycle, then one per cycle. In steady
    // state one word sits in RAM, one is in flight and one is at the head.
    pops = 0;
    for (int i = 0; i < 300; i++) step(1'b1, 12'(i + 1000), 1'b1);
    chk("stream_pops", pops, 32'd297);
    chk("stream_level", {24'd0, level}, 32'd3);
    drain();

    // Random back-pressure against the scoreboard.
    for (int i = 0; i < 5000; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 2047)),
           1'($urandom_range(0, 1)));
    end
    drain();

    // Reset with 50 words stored discards everything.
    for (int i = 0; i < 50; i++) step(1'b1, 12'(i + 300), 1'b0);
    chk("mid_level50", {24'd0, level}, 32'd50);
    rst_n = 1'b0;
    step(1'b1, 12'h123, 1'b1);
    rst_n = 1'b1;
    chk("mid_rst_level", {24'd0, level}, 32'd0);
    chk("mid_rst_valid", {31'd0, pop_valid}, 32'd0);
    step(1'b1, 12'h321, 1'b0);
    step(1'b1, 12'h432, 1'b0);
    step(1'b1, 12'h543, 1'b0);
    chk("mid_level3", {24'd0, level}, 32'd3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
